// File: rtl/rv32i_ctrl_pkg.sv
// RV32I pipelined control: shared opcodes, codes and control words.
// Imported by the decoder and the pipeline top.
package rv32i_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       jalr;
        logic [3:0] alu_ctrl;
        logic       alu_src;
        logic       alu_a_pc;
        logic [2:0] func3;
        logic       illegal;
    } de_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       illegal;
    } em_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       illegal;
    } mw_t;

    localparam de_t DE_BUBBLE = '0;
    localparam em_t EM_BUBBLE = '0;
    localparam mw_t MW_BUBBLE = '0;

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [3:0] r;
        case (f3)
            3'b000:  r = alt ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipelined_control_unit_decode.sv
// Combinational Decode-stage control decoder.
// Illegal encodings come out as a bubble with only the illegal bit set.
module ctrl_decode
    import rv32i_ctrl_pkg::*;
#(
    parameter int IMMSRC_W = 3,
    parameter bit EN_UPPER = 1'b1
) (
    input  logic [6:0]          op,
    input  logic [2:0]          func3,
    input  logic [6:0]          func7,
    output de_t                 ctrl,
    output logic [IMMSRC_W-1:0] imm_src,
    output logic                illegal
);

    de_t        c;
    logic [2:0] imm;
    logic       bad;
    logic       f7_zero;
    logic       f7_alt;

    assign f7_zero = (func7 == 7'b0000000);
    assign f7_alt  = (func7 == 7'b0100000);

    // Opcode/func decode into a raw control word and a legality flag
    always_comb begin
        c       = DE_BUBBLE;
        c.func3 = func3;
        imm     = IMM_I;
        bad     = 1'b0;
        unique case (op)
            OP_R: begin
                c.reg_write = 1'b1;
                c.alu_ctrl  = alu_op(func3, func7[5]);
                bad = !(f7_zero ||
                        (f7_alt && (func3 == 3'b000 || func3 == 3'b101)));
            end
            OP_I: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_ctrl  = alu_op(func3, (func3 == 3'b101) && func7[5]);
                if (func3 == 3'b001)
                    bad = !f7_zero;
                else if (func3 == 3'b101)
                    bad = !(f7_zero || f7_alt);
            end
            OP_LOAD: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_MEM;
                c.alu_src    = 1'b1;
                bad = func3 inside {3'b011, 3'b110, 3'b111};
            end
            OP_STORE: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                imm = IMM_S;
                bad = (func3 > 3'b010);
            end
            OP_BRANCH: begin
                c.branch   = 1'b1;
                c.alu_ctrl = ALU_SUB;
                imm = IMM_B;
                bad = func3 inside {3'b010, 3'b011};
            end
            OP_JAL: begin
                c.jump       = 1'b1;
                c.reg_write  = 1'b1;
                c.result_src = RES_PC4;
                c.alu_src    = 1'b1;
                c.alu_a_pc   = 1'b1;
                imm = IMM_J;
            end
            OP_JALR: begin
                c.jump       = 1'b1;
                c.jalr       = 1'b1;
                c.reg_write  = 1'b1;
                c.result_src = RES_PC4;
                c.alu_src    = 1'b1;
                bad = (func3 != 3'b000);
            end
            OP_LUI: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_IMM;
                c.alu_src    = 1'b1;
                imm = IMM_U;
                bad = !EN_UPPER;
            end
            OP_AUIPC: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_a_pc  = 1'b1;
                imm = IMM_U;
                bad = !EN_UPPER;
            end
            default: bad = 1'b1;
        endcase
    end

    // Replace illegal words by a flagged bubble
    always_comb begin
        ctrl = c;
        if (bad) begin
            ctrl         = DE_BUBBLE;
            ctrl.illegal = 1'b1;
        end
    end

    assign imm_src = IMMSRC_W'(imm);
    assign illegal = bad;

endmodule

// File: rtl/pipelined_control_unit.sv
// 5-stage RV32I control pipeline: decode, D/E, E/M, M/W control
// registers and the Execute-stage branch resolution.
module pipelined_control_unit
    import rv32i_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 4,
    parameter int IMMSRC_W  = 3,
    parameter bit EN_UPPER  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           op_d,
    input  logic [2:0]           func3_d,
    input  logic [6:0]           func7_d,
    input  logic                 stall_e,
    input  logic                 flush_e,
    input  logic                 zero_e,
    input  logic                 lt_e,
    input  logic                 ltu_e,
    output logic [IMMSRC_W-1:0]  imm_src_d,
    output logic                 illegal_d,
    output logic [ALUCTRL_W-1:0] alu_ctrl_e,
    output logic                 alu_src_e,
    output logic                 alu_a_pc_e,
    output logic                 jalr_e,
    output logic                 pc_src_e,
    output logic [1:0]           result_src_e,
    output logic                 mem_write_m,
    output logic                 reg_write_m,
    output logic [1:0]           result_src_w,
    output logic                 reg_write_w,
    output logic                 illegal_w
);

    if (ALUCTRL_W < 4) begin : g_bad_w
        $error("ALUCTRL_W must be at least 4");
    end

    de_t  ctrl_d;
    de_t  de;
    em_t  em;
    mw_t  mw;
    logic cond;

    ctrl_decode #(
        .IMMSRC_W (IMMSRC_W),
        .EN_UPPER (EN_UPPER)
    ) u_dec (
        .op      (op_d),
        .func3   (func3_d),
        .func7   (func7_d),
        .ctrl    (ctrl_d),
        .imm_src (imm_src_d),
        .illegal (illegal_d)
    );

    // Control-word pipeline: stall holds all, flush bubbles D/E
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de <= DE_BUBBLE;
            em <= EM_BUBBLE;
            mw <= MW_BUBBLE;
        end else if (!stall_e) begin
            de <= flush_e ? DE_BUBBLE : ctrl_d;
            em <= '{reg_write:  de.reg_write,
                    result_src: de.result_src,
                    mem_write:  de.mem_write,
                    illegal:    de.illegal};
            mw <= '{reg_write:  em.reg_write,
                    result_src: em.result_src,
                    illegal:    em.illegal};
        end
    end

    // Branch condition select and taken decision
    always_comb begin
        cond = 1'b0;
        unique case (de.func3)
            3'b000:  cond = zero_e;
            3'b001:  cond = !zero_e;
            3'b100:  cond = lt_e;
            3'b101:  cond = !lt_e;
            3'b110:  cond = ltu_e;
            3'b111:  cond = !ltu_e;
            default: cond = 1'b0;
        endcase
        pc_src_e = de.jump | (de.branch & cond);
    end

    assign alu_ctrl_e   = ALUCTRL_W'(de.alu_ctrl);
    assign alu_src_e    = de.alu_src;
    assign alu_a_pc_e   = de.alu_a_pc;
    assign jalr_e       = de.jalr;
    assign result_src_e = de.result_src;
    assign mem_write_m  = em.mem_write;
    assign reg_write_m  = em.reg_write;
    assign result_src_w = mw.result_src;
    assign reg_write_w  = mw.reg_write;
    assign illegal_w    = mw.illegal;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed self-checking bench for pipelined_control_unit.
// Expected values are hand-derived from the decode table and stage latencies.
module tb_pipelined_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op_d;
    logic [2:0] func3_d;
    logic [6:0] func7_d;
    logic       stall_e, flush_e, zero_e, lt_e, ltu_e;
    logic [2:0] imm_src_d;
    logic       illegal_d;
    logic [3:0] alu_ctrl_e;
    logic       alu_src_e, alu_a_pc_e, jalr_e, pc_src_e;
    logic [1:0] result_src_e;
    logic       mem_write_m, reg_write_m;
    logic [1:0] result_src_w;
    logic       reg_write_w, illegal_w;

    int passed = 0;
    int total  = 0;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] JLR = 7'b1100111;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] ALT = 7'b0100000;

    pipelined_control_unit dut (
        .clk          (clk),
        .rst          (rst),
        .op_d         (op_d),
        .func3_d      (func3_d),
        .func7_d      (func7_d),
        .stall_e      (stall_e),
        .flush_e      (flush_e),
        .zero_e       (zero_e),
        .lt_e         (lt_e),
        .ltu_e        (ltu_e),
        .imm_src_d    (imm_src_d),
        .illegal_d    (illegal_d),
        .alu_ctrl_e   (alu_ctrl_e),
        .alu_src_e    (alu_src_e),
        .alu_a_pc_e   (alu_a_pc_e),
        .jalr_e       (jalr_e),
        .pc_src_e     (pc_src_e),
        .result_src_e (result_src_e),
        .mem_write_m  (mem_write_m),
        .reg_write_m  (reg_write_m),
        .result_src_w (result_src_w),
        .reg_write_w  (reg_write_w),
        .illegal_w    (illegal_w)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [6:0] o, input logic [2:0] f3,
                         input logic [6:0] f7);
        op_d    = o;
        func3_d = f3;
        func7_d = f7;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; stall_e = 1'b0; flush_e = 1'b1;
        zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0;
        op_d = R; func3_d = 3'b000; func7_d = 7'b0;
        repeat (2) tick();
        chk("rst_alu_ctrl", alu_ctrl_e, 0);
        chk("rst_pc_src", pc_src_e, 0);
        chk("rst_reg_write_m", reg_write_m, 0);
        chk("rst_reg_write_w", reg_write_w, 0);
        chk("rst_illegal_w", illegal_w, 0);
        rst = 1'b0;

        // ALU ops: add, sub, sra, sltu
        flush_e = 1'b0;
        set_d(R, 3'b000, 7'b0);
        chk("add_illegal_d", illegal_d, 0);
        tick();
        chk("add_alu", alu_ctrl_e, 0);
        chk("add_src", alu_src_e, 0);
        chk("add_rw_m_early", reg_write_m, 0);
        set_d(R, 3'b000, ALT);
        tick();
        chk("sub_alu", alu_ctrl_e, 1);
        chk("add_rw_m", reg_write_m, 1);
        chk("add_rw_w_early", reg_write_w, 0);
        set_d(R, 3'b101, ALT);
        tick();
        chk("sra_alu", alu_ctrl_e, 9);
        chk("add_rw_w", reg_write_w, 1);
        chk("add_res_w", result_src_w, 0);
        set_d(R, 3'b011, 7'b0);
        tick();
        chk("sltu_alu", alu_ctrl_e, 6);
        flush_e = 1'b1;
        repeat (3) tick();
        chk("drain_rw_w", reg_write_w, 0);

        // Branches
        flush_e = 1'b0;
        set_d(BR, 3'b100, 7'b0);
        chk("blt_imm", imm_src_d, 2);
        lt_e = 1'b1;
        tick();
        chk("blt_taken", pc_src_e, 1);
        lt_e = 1'b0; ltu_e = 1'b1;
        set_d(BR, 3'b111, 7'b0);
        tick();
        chk("bgeu_not_taken", pc_src_e, 0);
        chk("blt_no_rw_m", reg_write_m, 0);
        ltu_e = 1'b0; zero_e = 1'b1;
        set_d(BR, 3'b000, 7'b0);
        tick();
        chk("beq_taken", pc_src_e, 1);
        flush_e = 1'b1;
        set_d(LD, 3'b010, 7'b0);
        tick();
        chk("flush_br_pc_src", pc_src_e, 0);
        chk("beq_rw_m", reg_write_m, 0);
        chk("beq_mw_m", mem_write_m, 0);
        zero_e = 1'b0;
        set_d(BR, 3'b010, 7'b0);
        chk("br_f3_010_illegal", illegal_d, 1);

        // Jumps and LUI
        flush_e = 1'b0;
        set_d(JAL, 3'b000, 7'b0);
        chk("jal_imm", imm_src_d, 3);
        tick();
        chk("jal_pc_src", pc_src_e, 1);
        chk("jal_a_pc", alu_a_pc_e, 1);
        chk("jal_res_e", result_src_e, 2);
        set_d(JLR, 3'b000, 7'b0);
        tick();
        chk("jalr_e", jalr_e, 1);
        chk("jalr_pc_src", pc_src_e, 1);
        chk("jal_rw_m", reg_write_m, 1);
        set_d(LUI, 3'b000, 7'b0);
        chk("lui_imm", imm_src_d, 4);
        tick();
        chk("lui_res_e", result_src_e, 3);
        chk("lui_pc_src", pc_src_e, 0);
        flush_e = 1'b1;
        repeat (2) tick();
        chk("lui_res_w", result_src_w, 3);
        chk("lui_rw_w", reg_write_w, 1);
        tick();

        // Load followed by a flushed slot
        flush_e = 1'b0;
        set_d(LD, 3'b010, 7'b0);
        chk("lw_imm", imm_src_d, 0);
        tick();
        chk("lw_res_e", result_src_e, 1);
        chk("lw_src_e", alu_src_e, 1);
        flush_e = 1'b1;
        set_d(R, 3'b000, 7'b0);
        tick();
        chk("flush_res_e", result_src_e, 0);
        chk("flush_src_e", alu_src_e, 0);
        chk("lw_rw_m", reg_write_m, 1);
        tick();
        chk("lw_rw_w", reg_write_w, 1);
        chk("lw_res_w", result_src_w, 1);
        chk("flushed_rw_m", reg_write_m, 0);
        chk("flushed_mw_m", mem_write_m, 0);
        tick();
        chk("flushed_rw_w", reg_write_w, 0);

        // Store held by a two-cycle stall
        flush_e = 1'b0;
        set_d(ST, 3'b010, 7'b0);
        chk("sw_imm", imm_src_d, 1);
        tick();
        set_d(R, 3'b000, ALT);
        tick();
        chk("sw_mw_m", mem_write_m, 1);
        stall_e = 1'b1; flush_e = 1'b1;
        tick();
        chk("stall1_mw_m", mem_write_m, 1);
        chk("stall1_alu", alu_ctrl_e, 1);
        chk("stall1_rw_w", reg_write_w, 0);
        tick();
        chk("stall2_mw_m", mem_write_m, 1);
        chk("stall2_alu", alu_ctrl_e, 1);
        chk("stall2_rw_m", reg_write_m, 0);
        stall_e = 1'b0;
        tick();
        chk("resume_alu", alu_ctrl_e, 0);
        chk("resume_rw_m", reg_write_m, 1);
        chk("resume_mw_m", mem_write_m, 0);
        chk("sw_rw_w", reg_write_w, 0);
        tick();
        chk("sub_rw_w", reg_write_w, 1);
        tick();

        // Illegal instructions
        flush_e = 1'b0;
        set_d(7'b1111111, 3'b000, 7'b0);
        chk("ill_op_d", illegal_d, 1);
        tick();
        chk("ill_bubble_alu", alu_ctrl_e, 0);
        chk("ill_bubble_pc", pc_src_e, 0);
        set_d(R, 3'b000, 7'b0000001);
        chk("ill_f7_d", illegal_d, 1);
        tick();
        flush_e = 1'b1;
        tick();
        chk("ill_op_w", illegal_w, 1);
        chk("ill_op_rw_w", reg_write_w, 0);
        tick();
        chk("ill_f7_w", illegal_w, 1);
        chk("ill_f7_rw_w", reg_write_w, 0);
        tick();
        chk("ill_clear_w", illegal_w, 0);

        // Asynchronous reset mid-stream
        flush_e = 1'b0;
        set_d(R, 3'b000, ALT);
        tick();
        set_d(JAL, 3'b000, 7'b0);
        tick();
        chk("pre_rst_pc_src", pc_src_e, 1);
        chk("pre_rst_rw_m", reg_write_m, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_pc_src", pc_src_e, 0);
        chk("async_rst_rw_m", reg_write_m, 0);
        chk("async_rst_a_pc", alu_a_pc_e, 0);
        chk("async_rst_alu", alu_ctrl_e, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
